sat_add_rr_scheduler: RTL

//   Shares one W-bit signed saturating adder between N_REQ requesters, each on a

---
 rtl/sat_add_pkg.sv | 20 ++
 rtl/signed_add_sat_w.sv | 33 +++
 rtl/sat_add_rr_scheduler.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sat_add_pkg.sv
// Shared types and constants for saturating arithmetic blocks.
package sat_add_pkg;

  // Clamp direction of a saturating result; at most one bit is ever set.
  typedef struct packed {
    logic pos;
    logic neg;
  } sat_flags_t;

  // Largest signed value of a w-bit two's complement word, zero-extended to 32 bits.
  function automatic logic [31:0] sat_max(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Bit pattern of the most negative w-bit value ({1,0..0}) in the low w bits.
  function automatic logic [31:0] sat_min(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/signed_add_sat_w.sv
// Combinational W-bit signed adder that clamps on overflow instead of wrapping.
module signed_add_sat_w
  import sat_add_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output sat_flags_t   flags_o
);

  localparam logic [31:0]  MaxWide = sat_max(W);
  localparam logic [31:0]  MinWide = sat_min(W);
  localparam logic [W-1:0] MaxVal  = MaxWide[W-1:0];
  localparam logic [W-1:0] MinVal  = MinWide[W-1:0];

  logic [W-1:0] raw;

  // Overflow only when both operands share a sign and the wrapped sum flips it.
  always_comb begin
    raw         = a_i + b_i;
    flags_o.pos = ~a_i[W-1] & ~b_i[W-1] & raw[W-1];
    flags_o.neg = a_i[W-1] & b_i[W-1] & ~raw[W-1];
    sum_o       = raw;
    if (flags_o.pos) begin
      sum_o = MaxVal;
    end else if (flags_o.neg) begin
      sum_o = MinVal;
    end
  end

endmodule

// File: rtl/sat_add_rr_scheduler.sv
// Round-robin scheduler sharing one saturating adder between N_REQ requesters.
// One registered output slot with backpressure and a saturating clamp counter.
module sat_add_rr_scheduler
  import sat_add_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned IdW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_sum,
  output logic [IdW-1:0]     out_id,
  output logic               out_sat_pos,
  output logic               out_sat_neg,
  output logic [CNT_W-1:0]   sat_count
);

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_sum_q, out_sum_d;
  logic [IdW-1:0]   out_id_q, out_id_d;
  sat_flags_t       out_flags_q, out_flags_d;
  logic [CNT_W-1:0] sat_count_q, sat_count_d;
  logic [IdW-1:0]   ptr_q, ptr_d;

  logic [N_REQ-1:0] grant;
  logic [IdW-1:0]   gnt_id;
  logic             accept;
  logic             fire;
  logic [W-1:0]     op_a, op_b;
  logic [W-1:0]     add_sum;
  sat_flags_t       add_flags;

  // Grant the first valid requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    int unsigned idx;
    logic        found;
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_id     = IdW'(idx);
      end
    end
  end

  assign accept    = ~out_valid_q | out_ready;
  // Ready is masked during reset so no operand is consumed while state is cleared.
  assign req_ready = (rst_n && accept) ? grant : '0;
  assign fire      = |(req_valid & req_ready);

  // Route the granted requester's operands to the single shared adder.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        op_a = req_a[i*W +: W];
        op_b = req_b[i*W +: W];
      end
    end
  end

  signed_add_sat_w #(
    .W(W)
  ) u_add (
    .a_i    (op_a),
    .b_i    (op_b),
    .sum_o  (add_sum),
    .flags_o(add_flags)
  );

  // Slot, pointer and counter next state: load on transfer, clear on drain, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_id_d    = out_id_q;
    out_flags_d = out_flags_q;
    sat_count_d = sat_count_q;
    ptr_d       = ptr_q;
    if (fire) begin
      out_valid_d = 1'b1;
      out_sum_d   = add_sum;
      out_id_d    = gnt_id;
      out_flags_d = add_flags;
      ptr_d       = IdW'((int'(gnt_id) + 1) % int'(N_REQ));
      if ((add_flags.pos || add_flags.neg) && (sat_count_q != '1)) begin
        sat_count_d = sat_count_q + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_id_q    <= '0;
      out_flags_q <= '0;
      sat_count_q <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_id_q    <= out_id_d;
      out_flags_q <= out_flags_d;
      sat_count_q <= sat_count_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_sum     = out_sum_q;
  assign out_id      = out_id_q;
  assign out_sat_pos = out_flags_q.pos;
  assign out_sat_neg = out_flags_q.neg;
  assign sat_count   = sat_count_q;

endmodule
